lm_mac_acc: RTL
===============

Name: lm_mac_acc

Overview:
- Downstream consumer of the 16x16 approximate log multiplier: accumulates a stream of 32-bit unsigned products into a wide accumulator.
- Emits one dot-product result per vector, on VEC_LEN beats or an early in_last.
- Valid/ready handshake on both sides; turns the combinational multiplier into a streaming MAC datapath.

Parameters:
- PROD_W, 32, product width; matches multiplier result width.
- ACC_W, 40, accumulator/result width; must be >= PROD_W.
- VEC_LEN, 16, beats per vector; legal range 1..2^16-1; 0 is illegal.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- clr  input  1  synchronous abort of the partial vector
- in_valid  input  1  product beat valid
- in_ready  output  1  block accepts a beat this cycle
- in_data  input  PROD_W  unsigned product from the multiplier
- in_last  input  1  final beat of the vector (early termination)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_data  output  ACC_W  accumulated sum
- out_count  output  CNT_W  beats summed; CNT_W = clog2(VEC_LEN+1)
- out_ovf  output  1  accumulator overflowed during this vector

Behaviour:
- Reset (rst=1 at a clock edge, any state):
  - state=ACC; acc=0; cnt=0; ovf=0.
  - out_valid=0, out_data=0, out_count=0, out_ovf=0.
  - rst overrides all other inputs, including mid-vector and mid-HOLD. The pending result is discarded.
- States: ACC, HOLD (2-state FSM).
- in_ready = (state==ACC); decoded from registered state only, with no combinational path from out_ready.
- ACC, beat accepted (in_valid & in_ready):
  - sum = acc + zero-extended in_data, computed at ACC_W+1 bits.
  - carry = sum[ACC_W]; acc_next = sum[ACC_W-1:0]; ovf_next = ovf | carry.
  - If cnt==VEC_LEN-1 or in_last:
    - out_data<=acc_next, out_count<=cnt+1, out_ovf<=ovf_next, out_valid<=1.
    - acc<=0, cnt<=0, ovf<=0; state<=HOLD.
  - Otherwise: acc<=acc_next, cnt<=cnt+1, ovf<=ovf_next.
- Latency: out_valid rises in the cycle after the final beat's accepting edge.
- in_last together with cnt==VEC_LEN-1 is one completion, not two.
- VEC_LEN=1: every beat completes.
- ACC, no beat: all registers hold.
- HOLD:
  - out_data, out_count and out_ovf stay stable while out_valid=1.
  - On out_valid & out_ready: out_valid<=0, state<=ACC.
  - Minimum one bubble cycle between result handshake and the next beat acceptance. Throughput is VEC_LEN beats per VEC_LEN+1 cycles at best.
- clr:
  - In ACC: acc<=0, cnt<=0, ovf<=0. A coincident beat is dropped; in_ready is still 1, so the producer sees it as consumed.
  - In HOLD: clr is ignored and the result is still delivered.
  - Priority: rst > clr > beat.
- in_data is unsigned. No sign extension.

Optional Feature:
- Macro: LM_MAC_ACC_SAT_EN.
- Defined: on carry, acc_next = all-ones(ACC_W). The accumulator stays saturated for the remainder of the vector, and out_ovf is still reported.
- Undefined: wrap modulo 2^ACC_W; out_ovf is the only indication of overflow.

Decomposition:
- Shared package lm_pkg:
  - LM_PROD_W=32 (shared with the multiplier top).
  - Default ACC_W and VEC_LEN constants.
  - Typedef for the FSM state enum {ACC, HOLD}.
  - clog2-based CNT_W function.
- One natural sub-module, lm_acc_add: ACC_W-bit adder with carry-out and optional saturation, selected by the macro. FSM and counter remain in lm_mac_acc.

Test Plan:
- Basic vector: VEC_LEN=4, beats 6,12,20,30, out_ready=1 -> out_valid one cycle after 4th beat, out_data=68, out_count=4, out_ovf=0; in_ready=0 for exactly one cycle.
- Backpressure: same stimulus, out_ready=0 for 5 cycles -> out_data=68 held stable, in_ready=0 throughout; a beat offered during HOLD is not accepted. After out_ready=1, in_ready returns next cycle.
- Early last: VEC_LEN=16, beats 100, 200 with in_last on the 2nd -> out_data=300, out_count=2; the next vector starts from acc=0.
- Overflow, ACC_W=33, VEC_LEN=3, three beats of 0xFFFFFFFF:
  - Without macro -> out_data=0x0FFFFFFFD, out_ovf=1.
  - With LM_MAC_ACC_SAT_EN -> out_data=0x1FFFFFFFF, out_ovf=1.
- clr/rst mid-vector:
  - Two beats 5,7, then clr, then 4 beats of 1 (VEC_LEN=4) -> out_data=4.
  - rst asserted in HOLD -> out_valid=0 the next cycle, and the result is never handshaken.
- Back-to-back: VEC_LEN=1, continuous in_valid with 3,9, out_ready=1 -> results 3 then 9. Each beat is accepted every other cycle.

Source files
------------

// File: rtl/lm_pkg.sv
// Shared constants, FSM state type and counter-width helper for the log-multiplier MAC path.
package lm_pkg;

    localparam int LM_PROD_W  = 32;
    localparam int LM_ACC_W   = 40;
    localparam int LM_VEC_LEN = 16;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } lm_state_e;

    // Wide enough to hold VEC_LEN itself, since out_count reports full vectors.
    function automatic int lm_cnt_w(input int vec_len);
        return $clog2(vec_len + 1);
    endfunction

endpackage

// File: rtl/lm_acc_add.sv
// ACC_W-bit accumulate adder with carry-out; saturates on carry when LM_MAC_ACC_SAT_EN is defined,
// otherwise wraps modulo 2^ACC_W.
module lm_acc_add #(
    parameter int ACC_W  = 40,
    parameter int PROD_W = 32
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] data_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              carry_o
);

    logic [ACC_W:0] sum_w;

    assign sum_w   = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, data_i};
    assign carry_o = sum_w[ACC_W];

`ifdef LM_MAC_ACC_SAT_EN
    assign sum_o = carry_o ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
    assign sum_o = sum_w[ACC_W-1:0];
`endif

endmodule

// File: rtl/lm_mac_acc.sv
// Streaming MAC accumulator: sums VEC_LEN product beats (or up to in_last) into one result.
// Optional saturation of the accumulator is selected with LM_MAC_ACC_SAT_EN.
module lm_mac_acc
    import lm_pkg::*;
#(
    parameter  int PROD_W  = LM_PROD_W,
    parameter  int ACC_W   = LM_ACC_W,
    parameter  int VEC_LEN = LM_VEC_LEN,
    localparam int CNT_W   = lm_cnt_w(VEC_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

    lm_state_e        state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic             beat;

    lm_acc_add #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_add (
        .acc_i   (acc_q),
        .data_i  (in_data),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    // Ready comes from registered state only, so out_ready never reaches in_ready.
    assign in_ready = (state_q == ACC);
    assign beat     = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            ACC: begin
                if (clr) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (beat) begin
                    if (in_last || cnt_q == LAST_CNT) begin
                        out_data_d  = add_sum;
                        out_count_d = cnt_q + CNT_W'(1);
                        out_ovf_d   = ovf_q | add_carry;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = HOLD;
                    end else begin
                        acc_d = add_sum;
                        cnt_d = cnt_q + CNT_W'(1);
                        ovf_d = ovf_q | add_carry;
                    end
                end
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule
